mem_stage_lsu: RTL and testbench

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

---
 rtl/mem_stage_lsu.sv | 206 ++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit with a three-state handshake
// (IDLE -> BUSY -> DONE) towards a data memory that can take any number
// of cycles to acknowledge.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   mem_read_in           load request (EX/MEM control)
//   mem_write_in          store request (wins when both requests are high)
//   func_3_bits_in        access size / signedness
//   alu_result_in         byte address
//   alu_read_data_2_in    store data
//   instruction_11_7_in   destination register
//   stall_out             freezes EX/MEM and upstream while an access is open
//   dmem_req_out/we_out   memory request and write strobe (BUSY only)
//   dmem_addr_out         word-aligned address
//   dmem_wdata_out        lane-replicated store data
//   dmem_be_out           byte enables
//   dmem_ack_in           memory completion (honoured only in BUSY)
//   dmem_rdata_in         read word, captured on the ack edge
//   load_data_out         formatted load result (held outside DONE)
//   load_valid_out        one-cycle load completion pulse
//   rd_out                destination register (held outside DONE)
//   misaligned_out        only with LSU_MISALIGN_CHECK_EN: misaligned access
//                         completed without a memory request
//
// Optional feature macro: LSU_MISALIGN_CHECK_EN
module mem_stage_lsu #(
  parameter int data_bits = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read_in,
  input  logic                 mem_write_in,
  input  logic [2:0]           func_3_bits_in,
  input  logic [data_bits-1:0] alu_result_in,
  input  logic [data_bits-1:0] alu_read_data_2_in,
  input  logic [4:0]           instruction_11_7_in,
  output logic                 stall_out,
  output logic                 dmem_req_out,
  output logic                 dmem_we_out,
  output logic [data_bits-1:0] dmem_addr_out,
  output logic [data_bits-1:0] dmem_wdata_out,
  output logic [3:0]           dmem_be_out,
  input  logic                 dmem_ack_in,
  input  logic [data_bits-1:0] dmem_rdata_in,
  output logic [data_bits-1:0] load_data_out,
  output logic                 load_valid_out,
  output logic [4:0]           rd_out
`ifdef LSU_MISALIGN_CHECK_EN
  ,
  output logic                 misaligned_out
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q, state_d;
  logic [data_bits-1:0] addr_q, addr_d;
  logic [data_bits-1:0] wdata_q, wdata_d;
  logic [3:0]           be_q, be_d;
  logic                 we_q, we_d;
  logic                 is_load_q, is_load_d;
  logic [2:0]           f3_q, f3_d;
  logic [1:0]           off_q, off_d;
  logic [4:0]           rd_pend_q, rd_pend_d;
  logic [4:0]           rd_q, rd_d;
  logic [data_bits-1:0] load_data_q, load_data_d;
  logic                 mis_q, mis_d;

  logic                 req_any;
  logic                 misalign;
  logic [data_bits-1:0] rd_shift_b;
  logic [data_bits-1:0] rd_shift_h;
  logic [data_bits-1:0] fmt_data;

  assign req_any = mem_read_in | mem_write_in;

  // func3[1:0]: 00 byte, 01 halfword, anything else is a word access.
`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = ((func_3_bits_in[1:0] == 2'b01) & alu_result_in[0]) |
                    (func_3_bits_in[1] & (alu_result_in[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Load formatting from the raw read word; halfword lane uses a[1] only.
  assign rd_shift_b = dmem_rdata_in >> {off_q, 3'b000};
  assign rd_shift_h = dmem_rdata_in >> {off_q[1], 4'b0000};

  always_comb begin
    case (f3_q)
      3'b000:  fmt_data = {{24{rd_shift_b[7]}}, rd_shift_b[7:0]};
      3'b001:  fmt_data = {{16{rd_shift_h[15]}}, rd_shift_h[15:0]};
      3'b100:  fmt_data = {24'd0, rd_shift_b[7:0]};
      3'b101:  fmt_data = {16'd0, rd_shift_h[15:0]};
      default: fmt_data = dmem_rdata_in;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    we_d        = we_q;
    is_load_d   = is_load_q;
    f3_d        = f3_q;
    off_d       = off_q;
    rd_pend_d   = rd_pend_q;
    rd_d        = rd_q;
    load_data_d = load_data_q;
    mis_d       = mis_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          addr_d    = {alu_result_in[data_bits-1:2], 2'b00};
          off_d     = alu_result_in[1:0];
          f3_d      = func_3_bits_in;
          is_load_d = ~mem_write_in;
          we_d      = mem_write_in;
          rd_pend_d = instruction_11_7_in;
          be_d      = 4'b1111;
          wdata_d   = alu_read_data_2_in;
          if (mem_write_in) begin
            case (func_3_bits_in[1:0])
              2'b00: begin
                be_d    = 4'b0001 << alu_result_in[1:0];
                wdata_d = {4{alu_read_data_2_in[7:0]}};
              end
              2'b01: begin
                be_d    = 4'b0011 << {alu_result_in[1], 1'b0};
                wdata_d = {2{alu_read_data_2_in[15:0]}};
              end
              default: ;
            endcase
          end
          if (misalign) begin
            // Skip the memory entirely; DONE reports the fault.
            state_d     = DONE;
            mis_d       = 1'b1;
            rd_d        = instruction_11_7_in;
            load_data_d = '0;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (dmem_ack_in) begin
          state_d = DONE;
          rd_d    = rd_pend_q;
          if (is_load_q) load_data_d = fmt_data;
        end
      end
      DONE: begin
        state_d = IDLE;
        mis_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      we_q        <= 1'b0;
      is_load_q   <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
      rd_pend_q   <= '0;
      rd_q        <= '0;
      load_data_q <= '0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      we_q        <= we_d;
      is_load_q   <= is_load_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      rd_pend_q   <= rd_pend_d;
      rd_q        <= rd_d;
      load_data_q <= load_data_d;
      mis_q       <= mis_d;
    end
  end

  assign stall_out      = ((state_q == IDLE) & req_any) | (state_q == BUSY);
  assign dmem_req_out   = (state_q == BUSY);
  assign dmem_we_out    = (state_q == BUSY) & we_q;
  assign dmem_addr_out  = addr_q;
  assign dmem_wdata_out = wdata_q;
  assign dmem_be_out    = be_q;
  assign load_data_out  = load_data_q;
  assign load_valid_out = (state_q == DONE) & is_load_q & ~mis_q;
  assign rd_out         = rd_q;
`ifdef LSU_MISALIGN_CHECK_EN
  assign misaligned_out = (state_q == DONE) & mis_q;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed cases followed by random
// loads/stores checked against a reference model built from the access rules.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_in, mem_write_in;
  logic [2:0]  func_3_bits_in;
  logic [31:0] alu_result_in, alu_read_data_2_in;
  logic [4:0]  instruction_11_7_in;
  logic        stall_out, dmem_req_out, dmem_we_out;
  logic [31:0] dmem_addr_out, dmem_wdata_out;
  logic [3:0]  dmem_be_out;
  logic        dmem_ack_in;
  logic [31:0] dmem_rdata_in;
  logic [31:0] load_data_out;
  logic        load_valid_out;
  logic [4:0]  rd_out;
`ifdef LSU_MISALIGN_CHECK_EN
  logic        misaligned_out;
`endif

  mem_stage_lsu #(.data_bits(32)) dut (
    .clk(clk), .rst(rst),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .func_3_bits_in(func_3_bits_in), .alu_result_in(alu_result_in),
    .alu_read_data_2_in(alu_read_data_2_in),
    .instruction_11_7_in(instruction_11_7_in),
    .stall_out(stall_out), .dmem_req_out(dmem_req_out),
    .dmem_we_out(dmem_we_out), .dmem_addr_out(dmem_addr_out),
    .dmem_wdata_out(dmem_wdata_out), .dmem_be_out(dmem_be_out),
    .dmem_ack_in(dmem_ack_in), .dmem_rdata_in(dmem_rdata_in),
    .load_data_out(load_data_out), .load_valid_out(load_valid_out),
    .rd_out(rd_out)
`ifdef LSU_MISALIGN_CHECK_EN
    , .misaligned_out(misaligned_out)
`endif
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] last_ld = '0;
  logic [4:0]  last_rd = '0;
  bit          ld_known = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---- reference model ----
  function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
    int sz;
    sz = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    return (a % sz) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int lane;
    lane = a % 4;
    case (f3)
      3'd0, 3'd4: return 4'(1 << lane);
      3'd1, 3'd5: return 4'(3 << (lane / 2 * 2));
      default:    return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'd0, 3'd4: return (d % 256) * 32'h0101_0101;
      3'd1, 3'd5: return (d % 65536) * 32'h0001_0001;
      default:    return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
    logic [31:0] v;
    int lane;
    lane = a % 4;
    case (f3)
      3'd0, 3'd4: begin
        v = (w >> (8 * lane)) % 256;
        if (f3 == 3'd0 && v >= 128) v = v - 256;
      end
      3'd1, 3'd5: begin
        v = (w >> (16 * (lane / 2))) % 65536;
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  // One complete access; delay = number of BUSY cycles before the ack cycle.
  task automatic do_access(input bit rd_en, input bit wr_en, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [4:0] rd, input int delay,
                           input logic [31:0] rdata);
    bit          mis, is_load;
    logic [31:0] exp;
    mis     = model_mis(f3, a);
    is_load = rd_en & ~wr_en;
    @(negedge clk);
    mem_read_in = rd_en; mem_write_in = wr_en; func_3_bits_in = f3;
    alu_result_in = a; alu_read_data_2_in = d; instruction_11_7_in = rd;
    #1;
    chk("idle_stall", stall_out, 1);
    chk("idle_req", dmem_req_out, 0);
    if (!mis) begin
      for (int c = 0; c <= delay; c++) begin
        @(negedge clk);
        chk("busy_req", dmem_req_out, 1);
        chk("busy_stall", stall_out, 1);
        chk("busy_addr", dmem_addr_out, a - (a % 4));
        chk("busy_be", dmem_be_out, is_load ? 4'hF : model_be(f3, a));
        chk("busy_we", dmem_we_out, !is_load);
        if (!is_load) chk("busy_wdata", dmem_wdata_out, model_wdata(f3, d));
        chk("busy_valid", load_valid_out, 0);
        chk("busy_rd_hold", rd_out, last_rd);
        dmem_ack_in   = (c == delay);
        dmem_rdata_in = (c == delay) ? rdata : $urandom;
        // EX/MEM is frozen in a real pipeline; scrambling proves the latch.
        alu_result_in = $urandom; alu_read_data_2_in = $urandom;
        func_3_bits_in = 3'($urandom); instruction_11_7_in = 5'($urandom);
      end
    end
    @(negedge clk);
    func_3_bits_in = f3; alu_result_in = a; alu_read_data_2_in = d;
    instruction_11_7_in = rd;
    dmem_ack_in = 1'($urandom); dmem_rdata_in = $urandom;
    #1;
    chk("done_stall", stall_out, 0);
    chk("done_req", dmem_req_out, 0);
    chk("done_valid", load_valid_out, is_load & !mis);
    chk("done_rd", rd_out, rd);
    last_rd = rd;
`ifdef LSU_MISALIGN_CHECK_EN
    chk("done_misaligned", misaligned_out, mis);
`endif
    if (mis) begin
      chk("done_mis_data", load_data_out, 0);
      last_ld = '0; ld_known = 1'b1;
    end else if (is_load) begin
      exp = model_load(f3, a, rdata);
      chk("done_data", load_data_out, exp);
      last_ld = exp; ld_known = 1'b1;
    end else begin
      ld_known = 1'b0;
    end
    mem_read_in = 1'b0; mem_write_in = 1'b0;
    @(negedge clk);
    chk("post_stall", stall_out, 0);
    chk("post_req", dmem_req_out, 0);
    chk("post_valid", load_valid_out, 0);
    chk("post_rd_hold", rd_out, last_rd);
    if (ld_known) chk("post_data_hold", load_data_out, last_ld);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("post_misaligned", misaligned_out, 0);
`endif
    dmem_ack_in = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req"}, dmem_req_out, 0);
    chk({tag, "_we"}, dmem_we_out, 0);
    chk({tag, "_valid"}, load_valid_out, 0);
    chk({tag, "_be"}, dmem_be_out, 0);
    chk({tag, "_addr"}, dmem_addr_out, 0);
    chk({tag, "_wdata"}, dmem_wdata_out, 0);
    chk({tag, "_data"}, load_data_out, 0);
    chk({tag, "_rd"}, rd_out, 0);
    chk({tag, "_stall"}, stall_out, 0);
  endtask

  logic [2:0] ld_f3 [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
  logic [2:0] st_f3 [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

  initial begin
    rst = 1'b1; mem_read_in = 1'b0; mem_write_in = 1'b0; func_3_bits_in = '0;
    alu_result_in = '0; alu_read_data_2_in = '0; instruction_11_7_in = '0;
    dmem_ack_in = 1'b0; dmem_rdata_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_state("reset");
`ifdef LSU_MISALIGN_CHECK_EN
    chk("reset_misaligned", misaligned_out, 0);
`endif

    // LW, ack in the first BUSY cycle
    do_access(1, 0, 3'd2, 32'h0000_0100, 32'h0, 5'd1, 0, 32'hDEAD_BEEF);
    // LB / LBU on the top byte lane
    do_access(1, 0, 3'd0, 32'h0000_0103, 32'h0, 5'd2, 1, 32'h80FF_FF00);
    do_access(1, 0, 3'd4, 32'h0000_0103, 32'h0, 5'd3, 0, 32'h80FF_FF00);
    // SH to the upper halfword
    do_access(0, 1, 3'd1, 32'h0000_0102, 32'h1234_ABCD, 5'd4, 0, 32'h0);
    // SW with ack four cycles late
    do_access(0, 1, 3'd2, 32'h0000_0200, 32'hCAFE_F00D, 5'd5, 4, 32'h0);
    // both requests high -> store
    do_access(1, 1, 3'd0, 32'h0000_0301, 32'h0000_0077, 5'd6, 2, 32'h0);

    // reset in the second BUSY cycle, ack arriving afterwards
    @(negedge clk);
    mem_read_in = 1'b1; func_3_bits_in = 3'd2; alu_result_in = 32'h100;
    instruction_11_7_in = 5'd9;
    @(negedge clk);
    chk("rstbusy_req1", dmem_req_out, 1);
    @(negedge clk);
    chk("rstbusy_req2", dmem_req_out, 1);
    rst = 1'b1; mem_read_in = 1'b0;
    @(negedge clk);
    rst = 1'b0; dmem_ack_in = 1'b1; dmem_rdata_in = 32'h1111_2222;
    #1;
    chk_reset_state("rstbusy");
    @(negedge clk);
    chk("rstbusy_late_req", dmem_req_out, 0);
    chk("rstbusy_late_valid", load_valid_out, 0);
    chk("rstbusy_late_rd", rd_out, 0);
    dmem_ack_in = 1'b0;
    last_ld = '0; last_rd = '0; ld_known = 1'b1;

`ifdef LSU_MISALIGN_CHECK_EN
    do_access(1, 0, 3'd2, 32'h0000_0101, 32'h0, 5'd7, 0, 32'h0);
`endif

    for (int i = 0; i < 60; i++) begin
      bit st;
      st = 1'($urandom);
      if (st)
        do_access(1'($urandom), 1, st_f3[$urandom_range(0, 5)], $urandom, $urandom,
                  5'($urandom), $urandom_range(0, 5), 32'h0);
      else
        do_access(1, 0, ld_f3[$urandom_range(0, 7)], $urandom, 32'h0,
                  5'($urandom), $urandom_range(0, 5), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
